hs_burst_master: RTL and testbench

HS_BURST_MASTER -- requirements
Module: hs_burst_master

---
 rtl/hs_pkg.sv | 21 ++
 rtl/hs_wait_timer.sv | 31 +++
 rtl/hs_burst_master.sv | 118 +++++++++++
 tb/tb_hs_burst_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - state encoding and default constants for the burst master
package hs_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ASSERT_REQ  = 3'd1,
        WAIT_ACK_HI = 3'd2,
        DROP_REQ    = 3'd3,
        WAIT_ACK_LO = 3'd4,
        NEXT_WORD   = 3'd5,
        DONE_ST     = 3'd6,
        ERR_ST      = 3'd7
    } hs_state_t;

    localparam int HS_DATA_W_DEF    = 8;
    localparam int HS_BURST_LEN_DEF = 4;
    localparam int HS_SEED_DEF      = 'hA0;
    localparam int HS_STEP_DEF      = 1;
    localparam int HS_TIMEOUT_DEF   = 16;

endpackage

// File: rtl/hs_wait_timer.sv
// rtl/hs_wait_timer.sv - ack wait counter with expiry flag
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : hold the count at zero (outside a wait phase)
//   tick      : one more cycle without the awaited ack level
//   expired   : this tick brings the count to LIMIT
module hs_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    // Flag on the tick that would make the count equal LIMIT, so the FSM
    // leaves the wait state on exactly the LIMIT-th empty cycle.
    assign expired = tick && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/hs_burst_master.sv
// rtl/hs_burst_master.sv - 4-phase req/ack burst master with optional timeout (HS_TIMEOUT_EN)
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : single-cycle burst launch (honoured in IDLE/DONE_ST/ERR_ST)
//   ack_in    : slave acknowledge, 4-phase
//   req_out   : request to slave
//   data_out  : current word, SEED + n*STEP
//   busy_out  : burst in progress
//   done_out  : burst completed, sticky until next start or reset
//   err_out   : ack timeout, sticky (tied 0 unless HS_TIMEOUT_EN is defined)
//   word_cnt  : words fully handshaken in the current burst
module hs_burst_master
    import hs_pkg::*;
#(
    parameter int                DATA_W      = HS_DATA_W_DEF,
    parameter int                BURST_LEN   = HS_BURST_LEN_DEF,
    parameter logic [DATA_W-1:0] SEED        = DATA_W'(HS_SEED_DEF),
    parameter logic [DATA_W-1:0] STEP        = DATA_W'(HS_STEP_DEF),
    parameter int                TIMEOUT_CYC = HS_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack_in,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    output logic [7:0]        word_cnt
);

    hs_state_t state;
    hs_state_t nxt;
    logic      expired;
    logic      launch;
    logic      word_done;

`ifdef HS_TIMEOUT_EN
    logic wt_clear;
    logic wt_tick;

    // Only the two wait states ever count, and they are never adjacent,
    // so holding the counter clear elsewhere clears it on every entry.
    assign wt_clear = (state != WAIT_ACK_HI) && (state != WAIT_ACK_LO);
    assign wt_tick  = ((state == WAIT_ACK_HI) && !ack_in) ||
                      ((state == WAIT_ACK_LO) &&  ack_in);

    hs_wait_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wt_clear),
        .tick   (wt_tick),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign expired        = 1'b0;
    assign err_out        = 1'b0;
`endif

    assign launch    = start && ((state == IDLE) || (state == DONE_ST) || (state == ERR_ST));
    assign word_done = (state == WAIT_ACK_LO) && !ack_in;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE_ST, ERR_ST: if (start) nxt = ASSERT_REQ;
            ASSERT_REQ:            nxt = WAIT_ACK_HI;
            WAIT_ACK_HI: begin
                if (ack_in)       nxt = DROP_REQ;
                else if (expired) nxt = ERR_ST;
            end
            DROP_REQ:              nxt = WAIT_ACK_LO;
            WAIT_ACK_LO: begin
                if (!ack_in)      nxt = NEXT_WORD;
                else if (expired) nxt = ERR_ST;
            end
            NEXT_WORD:             nxt = (word_cnt == 8'(BURST_LEN)) ? DONE_ST : ASSERT_REQ;
            default:               nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they always equal a
    // decode of the current state without any path from ack_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_out <= SEED;
            word_cnt <= 8'd0;
            req_out  <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
`ifdef HS_TIMEOUT_EN
            err_out  <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            req_out  <= (nxt == ASSERT_REQ) || (nxt == WAIT_ACK_HI);
            busy_out <= (nxt != IDLE) && (nxt != DONE_ST) && (nxt != ERR_ST);
            done_out <= (nxt == DONE_ST);
`ifdef HS_TIMEOUT_EN
            err_out  <= (nxt == ERR_ST);
`endif
            if (launch) begin
                data_out <= SEED;
                word_cnt <= 8'd0;
            end else if (word_done) begin
                data_out <= data_out + STEP;
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hs_burst_master.sv
// tb/tb_hs_burst_master.sv - scoreboard bench for hs_burst_master
module tb_hs_burst_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ack_in = 1'b0;
    logic       req_out, busy_out, done_out, err_out;
    logic [7:0] data_out, word_cnt;

    logic       b_start = 1'b0;
    logic       b_ack = 1'b0;
    logic       b_req, b_busy, b_done, b_err;
    logic [3:0] b_data;
    logic [7:0] b_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [3:0] b_q[$];
    int         ack_dly = 0;
    bit         mute = 1'b0;
    int         words_done = 0;

    always #5 clk = ~clk;

    hs_burst_master u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ack_in  (ack_in),
        .req_out (req_out),
        .data_out(data_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .err_out (err_out),
        .word_cnt(word_cnt)
    );

    hs_burst_master #(
        .DATA_W   (4),
        .BURST_LEN(4),
        .SEED     (4'hE),
        .STEP     (4'h1)
    ) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (b_start),
        .ack_in  (b_ack),
        .req_out (b_req),
        .data_out(b_data),
        .busy_out(b_busy),
        .done_out(b_done),
        .err_out (b_err),
        .word_cnt(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_a();
        logic [7:0] vec [4];
        vec = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) exp_q.push_back(vec[i]);
        words_done = 0;
    endtask

    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            b_start = 1'b0;
        end while (!done_out && cyc < limit);
        if (!done_out) check({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    // Slave model for the default instance: optional ack delay per phase,
    // checks the word against the scoreboard when it acknowledges.
    initial begin : slave_a
        logic [7:0] held;
        bit         moved;
        int         hw;
        int         lw;
        held = '0; moved = 1'b0; hw = 0; lw = 0;
        forever begin
            @(negedge clk);
            if (!req_out && !ack_in) begin
                hw = 0;
                lw = 0;
            end else if (req_out && !ack_in && !mute) begin
                if (hw == 0) begin
                    held  = data_out;
                    moved = 1'b0;
                end else if (data_out !== held) begin
                    moved = 1'b1;
                end
                if (hw >= ack_dly) begin
                    check("data_stable", {31'd0, moved}, 32'd0);
                    if (exp_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                    else check("word_data", data_out, exp_q.pop_front());
                    check("word_cnt_at_req", word_cnt, words_done);
                    ack_in = 1'b1;
                    hw = 0;
                end else begin
                    hw++;
                end
            end else if (!req_out && ack_in) begin
                if (lw >= ack_dly) begin
                    ack_in = 1'b0;
                    lw = 0;
                    words_done++;
                end else begin
                    lw++;
                end
            end
        end
    end

    initial begin : slave_b
        forever begin
            @(negedge clk);
            if (b_req && !b_ack) begin
                if (b_q.size() == 0) check("b_unexpected_req", 32'd1, 32'd0);
                else check("b_word_data", b_data, b_q.pop_front());
                b_ack = 1'b1;
            end else if (!b_req && b_ack) begin
                b_ack = 1'b0;
            end
        end
    end

    initial begin : stim
        int cyc;
        int hi;
        repeat (2) @(negedge clk);
        check("rst_req", req_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_err", err_out, 0);
        check("rst_cnt", word_cnt, 0);
        check("rst_data", data_out, 8'hA0);
        check("rst_b_data", b_data, 4'hE);
        rst = 1'b0;
        @(negedge clk);

        // Defaults with 1-cycle responder, plus 4-bit wrap-around instance.
        push_a();
        b_q.push_back(4'hE); b_q.push_back(4'hF); b_q.push_back(4'h0); b_q.push_back(4'h1);
        start = 1'b1;
        b_start = 1'b1;
        wait_done("burst1", 60, cyc);
        check("burst1_latency", cyc, 21);
        check("burst1_cnt", word_cnt, 4);
        check("burst1_busy", busy_out, 0);
        check("burst1_data_end", data_out, 8'hA4);
        check("b_done", b_done, 1);
        check("b_cnt", b_cnt, 4);
        check("b_data_end", b_data, 4'h2);
        repeat (10) @(negedge clk);
        check("idle_no_req", req_out, 0);
        check("done_sticky", done_out, 1);
        check("burst1_q_empty", exp_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);

        // Slow slave, 7 extra cycles per phase.
        ack_dly = 7;
        push_a();
        start = 1'b1;
        wait_done("slow", 400, cyc);
        check("slow_cnt", word_cnt, 4);
        check("slow_q_empty", exp_q.size(), 0);

        // Reset while word 2 is waiting for ack high.
        push_a();
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!(word_cnt == 8'd1 && req_out) && cyc < 200);
        check("word2_reached", {31'd0, (word_cnt == 8'd1 && req_out)}, 32'd1);
        @(negedge clk);
        check("word2_req_high", req_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_req", req_out, 0);
        check("midrst_cnt", word_cnt, 0);
        check("midrst_data", data_out, 8'hA0);
        check("midrst_busy", busy_out, 0);
        exp_q.delete();
        ack_dly = 0;
        repeat (2) @(negedge clk);
        push_a();
        start = 1'b1;
        wait_done("replay", 60, cyc);
        check("replay_cnt", word_cnt, 4);
        check("replay_q_empty", exp_q.size(), 0);

        // start pulsed mid-burst is ignored.
        push_a();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        wait_done("midstart", 60, cyc);
        check("midstart_latency", cyc, 14);
        check("midstart_cnt", word_cnt, 4);
        check("midstart_q_empty", exp_q.size(), 0);

        // rst and start together: rst wins.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rststart_busy", busy_out, 0);
        check("rststart_req", req_out, 0);
        check("rststart_done", done_out, 0);
        check("rststart_cnt", word_cnt, 0);
        repeat (10) @(negedge clk);
        check("rststart_idle_req", req_out, 0);
        check("rststart_idle_busy", busy_out, 0);

        // Slave never acknowledges.
        mute = 1'b1;
        start = 1'b1;
`ifdef HS_TIMEOUT_EN
        cyc = 0;
        hi = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            if (req_out) hi++;
            cyc++;
        end while (!err_out && cyc < 100);
        check("to_err", err_out, 1);
        check("to_req_cycles", hi, 17);
        check("to_req", req_out, 0);
        check("to_cnt", word_cnt, 0);
        check("to_busy", busy_out, 0);
        mute = 1'b0;
        push_a();
        start = 1'b1;
        wait_done("recover", 60, cyc);
        check("recover_err", err_out, 0);
        check("recover_cnt", word_cnt, 4);
`else
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (err_out) hi++;
        end
        check("noto_err", hi, 0);
        check("noto_req", req_out, 1);
        check("noto_busy", busy_out, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mute = 1'b0;
        check("noto_rst_busy", busy_out, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
